// File: rtl/multiply_pipe_pkg.sv
// Shared fixed-point constants and the dequantize helper used by datapath multipliers.
// Pure combinational function; no latency or flow control of its own.
package multiply_pipe_pkg;

    localparam int DEFAULT_DATA_SIZE = 32;
    localparam int DEFAULT_FRAC_BITS = 10;
    localparam int DEFAULT_DEPTH     = 4;
    localparam int PROD_MAX_W        = 128;

    // Products up to PROD_MAX_W bits are sign-extended by the caller; result truncates toward zero.
    function automatic logic signed [PROD_MAX_W-1:0] dequantize(
        input logic signed [PROD_MAX_W-1:0] p,
        input int                           frac
    );
        logic signed [PROD_MAX_W-1:0] mag;
        if (p[PROD_MAX_W-1]) begin
            mag        = -p;
            dequantize = -(mag >>> frac);
        end else begin
            dequantize = p >>> frac;
        end
    endfunction

endpackage

// File: rtl/mult_out_buf.sv
// First-word-fall-through result buffer, DEPTH words deep; head is valid the cycle after a push.
// No internal backpressure: the producer must reserve space before pushing.
module mult_out_buf
    import multiply_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_SIZE,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
        if (ptr == PW'(DEPTH-1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = ptr + 1'b1;
        end
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/multiply_pipe.sv
// Signed fixed-point multiplier between FIFOs; 2-cycle pop-to-output latency, pops gated by buffer credit.
// out_full stalls the buffer head; define MULTIPLY_PIPE_SAT_EN for saturating results and sat_flag.
module multiply_pipe
    import multiply_pipe_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] x,
    output logic                        x_in_rd_en,
    input  logic                        x_in_empty,
    input  logic signed [DATA_SIZE-1:0] y,
    output logic                        y_in_rd_en,
    input  logic                        y_in_empty,
    output logic signed [DATA_SIZE-1:0] mult_out,
    output logic                        out_wr_en,
    input  logic                        out_full
`ifdef MULTIPLY_PIPE_SAT_EN
    ,
    output logic                        sat_flag
`endif
);

    localparam int PW = 2 * DATA_SIZE;
    localparam int CW = $clog2(DEPTH+1);
`ifdef MULTIPLY_PIPE_SAT_EN
    localparam int BUF_W = DATA_SIZE + 1;
`else
    localparam int BUF_W = DATA_SIZE;
`endif

    logic                        s1_vld;
    logic signed [DATA_SIZE-1:0] s1_x;
    logic signed [DATA_SIZE-1:0] s1_y;
    logic signed [PW-1:0]        x_ext;
    logic signed [PW-1:0]        y_ext;
    logic signed [PW-1:0]        prod;
    logic [BUF_W-1:0]            push_dat;
    logic [BUF_W-1:0]            head;
    logic                        buf_empty;
    logic [CW-1:0]               buf_count;
    logic [CW:0]                 occupancy;
    logic                        pop_in;

    // Words in S1 have a buffer slot reserved so backpressure never overflows the buffer.
    assign occupancy  = (CW+1)'(buf_count) + (CW+1)'(s1_vld);
    assign pop_in     = !reset && !x_in_empty && !y_in_empty && (occupancy < (CW+1)'(DEPTH));
    assign x_in_rd_en = pop_in;
    assign y_in_rd_en = pop_in;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_vld <= pop_in;
            if (pop_in) begin
                s1_x <= x;
                s1_y <= y;
            end
        end
    end

    assign x_ext = {{DATA_SIZE{s1_x[DATA_SIZE-1]}}, s1_x};
    assign y_ext = {{DATA_SIZE{s1_y[DATA_SIZE-1]}}, s1_y};
    assign prod  = x_ext * y_ext;

`ifdef MULTIPLY_PIPE_SAT_EN
    logic signed [PW-1:0]        dq_full;
    logic                        ovf;
    logic signed [DATA_SIZE-1:0] dq_res;

    assign dq_full = PW'(dequantize({{(PROD_MAX_W-PW){prod[PW-1]}}, prod}, FRAC_BITS));
    // In range only when every bit above the result sign bit repeats it.
    assign ovf     = !((&dq_full[PW-1:DATA_SIZE-1]) || !(|dq_full[PW-1:DATA_SIZE-1]));
    assign dq_res  = !ovf           ? dq_full[DATA_SIZE-1:0] :
                     dq_full[PW-1]  ? {1'b1, {(DATA_SIZE-1){1'b0}}} :
                                      {1'b0, {(DATA_SIZE-1){1'b1}}};
    assign push_dat = {ovf, dq_res};
`else
    assign push_dat = DATA_SIZE'(dequantize({{(PROD_MAX_W-PW){prod[PW-1]}}, prod}, FRAC_BITS));
`endif

    mult_out_buf #(
        .WIDTH (BUF_W),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (s1_vld),
        .push_data (push_dat),
        .pop       (out_wr_en),
        .head      (head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign out_wr_en = !reset && !buf_empty && !out_full;
    assign mult_out  = out_wr_en ? head[DATA_SIZE-1:0] : '0;
`ifdef MULTIPLY_PIPE_SAT_EN
    assign sat_flag  = out_wr_en && head[DATA_SIZE];
`endif

endmodule
